seq_mul8: RTL and testbench



---
 rtl/mul8_pkg.sv | 16 +
 rtl/myadd8.sv | 15 +
 rtl/seq_mul8.sv | 102 ++++++++++
 tb/tb_seq_mul8.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mul8_pkg.sv
// Shared types and constants for the sequential 8x8 multiplier.
package mul8_pkg;

    localparam int WIDTH = 8;
    localparam int PW    = 2 * WIDTH;

    // Count value of the final add/shift step.
    localparam logic [2:0] STEP_LAST = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/myadd8.sv
// Combinational 8-bit ripple adder with carry in and carry out.
module myadd8 (
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic       cin,
    output logic [7:0] s,
    output logic       cout
);

    // Single 9-bit add; the top bit is the carry out.
    always_comb begin
        {cout, s} = {1'b0, x} + {1'b0, y} + {8'd0, cin};
    end

endmodule

// File: rtl/seq_mul8.sv
// Sequential unsigned shift-and-add multiplier: one add/shift step per clock,
// eight steps per product, registered product with a one-cycle done pulse.
module seq_mul8
    import mul8_pkg::*;
#(
    parameter int WIDTH = mul8_pkg::WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   p
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t             state;
    logic [WIDTH-1:0]   a;      // upper partial product
    logic [WIDTH-1:0]   m;      // captured multiplicand
    logic [WIDTH-1:0]   q;      // multiplier, shifted out as product low half
    logic [CNT_W-1:0]   cnt;

    logic [WIDTH-1:0]   sum;
    logic               cout;
    logic               c_n;    // adder carry; must survive into A[7] on shift
    logic [WIDTH-1:0]   a_n;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   q_sh;

    myadd8 u_add (
        .x    (a),
        .y    (m),
        .cin  (1'b0),
        .s    (sum),
        .cout (cout)
    );

    // Conditional add of M, then shift {C,A,Q} right by one.
    always_comb begin
        c_n  = 1'b0;
        a_n  = a;
        if (q[0]) begin
            c_n = cout;
            a_n = sum;
        end
        a_sh = {c_n, a_n[WIDTH-1:1]};
        q_sh = {a_n[0], q[WIDTH-1:1]};
    end

    // Control FSM, step counter, datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            p     <= '0;
            a     <= '0;
            m     <= '0;
            q     <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a     <= '0;
                        m     <= x;
                        q     <= y;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a   <= a_sh;
                    q   <= q_sh;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(STEP_LAST)) begin
                        // Whole product lands in one edge; p never shows a partial value.
                        p     <= {a_sh, q_sh};
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mul8.sv
// Self-checking bench for seq_mul8: vector table plus hand-written corner cases,
// expected products queued at accept and checked when done pulses.
module tb_seq_mul8;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  x;
    logic [7:0]  y;
    logic        busy;
    logic        done;
    logic [15:0] p;

    int          nvec;
    int          nerr;
    int          ndone;
    int          cyc;
    int          last_done_cyc;
    logic [15:0] expq[$];

    typedef struct {
        logic [7:0]  x;
        logic [7:0]  y;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[8];

    seq_mul8 dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .x     (x),
        .y     (y),
        .busy  (busy),
        .done  (done),
        .p     (p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: every done pops one expected product.
    always @(negedge clk) begin
        if (done) begin
            ndone++;
            last_done_cyc = cyc;
            if (expq.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL unexpected_done: p=%0d with nothing pending (cycle %0d)", p, cyc);
            end else begin
                chk("product", int'(p), int'(expq.pop_front()));
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            nvec++;
            nerr++;
            $display("FAIL idle_timeout: busy=%0d, expected 0", busy);
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (expq.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (expq.size() != 0) begin
            nvec++;
            nerr++;
            $display("FAIL done_timeout: %0d products pending, expected 0", expq.size());
            expq.delete();
        end
    endtask

    // One op: operands zeroed right after the accepting edge.
    task automatic run_op(input logic [7:0] xa, input logic [7:0] ya);
        wait_idle();
        x = xa; y = ya; start = 1'b1;
        expq.push_back(16'(xa * ya));
        @(negedge clk);
        start = 1'b0; x = 8'd0; y = 8'd0;
        wait_drain();
    endtask

    initial begin
        int n;
        int d0;
        int c1;
        int c2;
        int c3;
        logic [15:0] prev;

        nvec = 0; nerr = 0; ndone = 0; cyc = 0; last_done_cyc = 0;
        rst = 1'b1; start = 1'b0; x = 8'd0; y = 8'd0;

        vecs[0] = '{8'd0,   8'd0,   16'd0};
        vecs[1] = '{8'd255, 8'd255, 16'd65025};
        vecs[2] = '{8'd77,  8'd55,  16'd4235};
        vecs[3] = '{8'd123, 8'd246, 16'd30258};
        vecs[4] = '{8'd99,  8'd44,  16'd4356};
        vecs[5] = '{8'd0,   8'd200, 16'd0};
        vecs[6] = '{8'd1,   8'd1,   16'd1};
        vecs[7] = '{8'd128, 8'd2,   16'd256};

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_p", int'(p), 0);
        rst = 1'b0;

        // 0x0: busy 9 cycles, done exactly 8 edges after accept.
        @(negedge clk);
        start = 1'b1; expq.push_back(16'd0);
        d0 = ndone;
        @(negedge clk);
        c1 = cyc;                     // cycle count at the accepting edge
        start = 1'b0;
        n = 0;
        while (busy && n < 30) begin
            n++;
            @(negedge clk);
        end
        chk("busy_len", n, 9);
        chk("zero_ndone", ndone - d0, 1);
        chk("done_latency", last_done_cyc - c1, 8);

        // Vector table.
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].x, vecs[i].y);
            chk("table_p", int'(p), int'(vecs[i].exp));
        end

        // Random operands against a plain multiply.
        for (int i = 0; i < 6; i++) begin
            run_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        end

        // Back-to-back with start held high.
        wait_idle();
        x = 8'd77; y = 8'd55; start = 1'b1; expq.push_back(16'd4235);
        d0 = ndone;
        n = 0;
        while (ndone - d0 < 1 && n < 30) begin @(negedge clk); n++; end
        c1 = last_done_cyc; prev = 16'd4235;
        x = 8'd123; y = 8'd246; expq.push_back(16'd30258);
        repeat (5) @(negedge clk);
        chk("hold_p1", int'(p), int'(prev));
        n = 0;
        while (ndone - d0 < 2 && n < 30) begin @(negedge clk); n++; end
        c2 = last_done_cyc; prev = 16'd30258;
        x = 8'd99; y = 8'd44; expq.push_back(16'd4356);
        repeat (5) @(negedge clk);
        chk("hold_p2", int'(p), int'(prev));
        n = 0;
        while (ndone - d0 < 3 && n < 30) begin @(negedge clk); n++; end
        c3 = last_done_cyc;
        start = 1'b0;
        chk("b2b_gap1", c2 - c1, 10);
        chk("b2b_gap2", c3 - c2, 10);
        wait_drain();

        // Start while busy is ignored, in RUN and in DONE.
        wait_idle();
        x = 8'd144; y = 8'd222; start = 1'b1; expq.push_back(16'd31968);
        d0 = ndone;
        @(negedge clk);               // after accepting edge k
        start = 1'b0; x = 8'd1; y = 8'd1;
        @(negedge clk);               // after k+1
        @(negedge clk);               // after k+2
        start = 1'b1;                 // sampled at k+3
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);    // after k+7
        start = 1'b1;                 // sampled at k+8 (RUN) and k+9 (DONE)
        repeat (2) @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        chk("busy_ign_ndone", ndone - d0, 1);
        chk("busy_ign_p", int'(p), 31968);
        chk("busy_ign_idle", int'(busy), 0);

        // Reset mid-operation.
        wait_idle();
        x = 8'd255; y = 8'd255; start = 1'b1;
        @(negedge clk);               // after accepting edge k
        start = 1'b0;
        repeat (3) @(negedge clk);    // after k+3
        rst = 1'b1;                   // sampled at k+4
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_p", int'(p), 0);
        d0 = ndone;
        repeat (12) @(negedge clk);
        chk("midrst_nodone", ndone - d0, 0);
        run_op(8'd77, 8'd55);
        chk("after_rst_p", int'(p), 4235);

        // Operand change right after accept.
        run_op(8'd99, 8'd44);
        chk("opchg_p", int'(p), 4356);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
